// File: rtl/lorenz_iter_ctrl_if.sv
// Bus bundle between the Lorenz sequencing controller and its environment:
// configuration/status from the register bank, the integration-core step
// handshake and the ready/valid sample port.
interface lorenz_iter_ctrl_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
);
  // Run configuration and status
  logic              cfg_start;
  logic              cfg_abort;
  logic [CNT_W-1:0]  cfg_steps;
  logic [15:0]       cfg_decim;
  logic [DATA_W-1:0] cfg_x0;
  logic [DATA_W-1:0] cfg_y0;
  logic [DATA_W-1:0] cfg_z0;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  iter_cnt;

  // Integration core step handshake
  logic              core_req;
  logic [DATA_W-1:0] core_x;
  logic [DATA_W-1:0] core_y;
  logic [DATA_W-1:0] core_z;
  logic              core_ack;
  logic [DATA_W-1:0] core_xn;
  logic [DATA_W-1:0] core_yn;
  logic [DATA_W-1:0] core_zn;

  // Sample stream
  logic              smp_valid;
  logic              smp_ready;
  logic [DATA_W-1:0] smp_x;
  logic [DATA_W-1:0] smp_y;
  logic [DATA_W-1:0] smp_z;
  logic              smp_last;

  // Controller side
  modport master (
    input  cfg_start, cfg_abort, cfg_steps, cfg_decim, cfg_x0, cfg_y0, cfg_z0,
    output busy, done, iter_cnt,
    output core_req, core_x, core_y, core_z,
    input  core_ack, core_xn, core_yn, core_zn,
    output smp_valid, smp_x, smp_y, smp_z, smp_last,
    input  smp_ready
  );

  // Environment side (register bank, core, sample sink)
  modport slave (
    output cfg_start, cfg_abort, cfg_steps, cfg_decim, cfg_x0, cfg_y0, cfg_z0,
    input  busy, done, iter_cnt,
    input  core_req, core_x, core_y, core_z,
    output core_ack, core_xn, core_yn, core_zn,
    input  smp_valid, smp_x, smp_y, smp_z, smp_last,
    output smp_ready
  );
endinterface

// File: rtl/lorenz_iter_ctrl.sv
// Sequencing controller for the Lorenz integration core: steps the core one
// Euler step at a time, feeds results back as operands, emits every Nth state
// (and always the last) on a ready/valid port, and reports busy/done/count.
module lorenz_iter_ctrl #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 32
) (
  input  logic               ACLK,
  input  logic               ARESET,
  lorenz_iter_ctrl_if.master bus
);

  localparam int unsigned DECIM_W = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_STEP,
    S_EMIT,
    S_DONE
  } state_t;

  state_t               r_state;
  state_t               w_next;

  logic                 w_start_acc;
  logic                 w_ack_acc;
  logic                 w_done_set;
  logic                 w_last;
  logic                 w_dcnt_hit;
  logic [DECIM_W-1:0]   w_dcnt_inc;
  logic [CNT_W-1:0]     w_iter_inc;

  logic [DATA_W-1:0]    r_core_x, r_core_y, r_core_z;
  logic [DATA_W-1:0]    r_smp_x, r_smp_y, r_smp_z;
  logic [CNT_W-1:0]     r_steps;
  logic [CNT_W-1:0]     r_iter_cnt;
  logic [DECIM_W-1:0]   r_decim;
  logic [DECIM_W-1:0]   r_dcnt;
  logic                 r_emit;
  logic                 r_core_req;
  logic                 r_smp_valid;
  logic                 r_smp_last;
  logic                 r_busy;
  logic                 r_done;

  assign w_last     = (r_iter_cnt == r_steps);
  assign w_dcnt_inc = r_dcnt + DECIM_W'(1);
  assign w_dcnt_hit = (w_dcnt_inc == r_decim);
  assign w_iter_inc = r_iter_cnt + CNT_W'(1);

  // State register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic and per-cycle strobes; abort wins over everything
  always_comb begin
    w_next      = r_state;
    w_start_acc = 1'b0;
    w_ack_acc   = 1'b0;
    w_done_set  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.cfg_start && !bus.cfg_abort) begin
          w_start_acc = 1'b1;
          w_next      = (bus.cfg_steps == '0) ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (bus.cfg_abort) begin
          w_next = S_IDLE;
        end else if (bus.core_ack) begin
          w_ack_acc = 1'b1;
          w_next    = S_STEP;
        end
      end
      S_STEP: begin
        if (bus.cfg_abort) begin
          w_next = S_IDLE;
        end else if (r_emit) begin
          w_next = S_EMIT;
        end else if (r_iter_cnt < r_steps) begin
          w_next = S_REQ;
        end else begin
          w_next = S_DONE;
        end
      end
      S_EMIT: begin
        if (bus.cfg_abort) begin
          w_next = S_IDLE;
        end else if (bus.smp_ready) begin
          w_next = w_last ? S_DONE : S_REQ;
        end
      end
      S_DONE: begin
        w_next     = S_IDLE;
        w_done_set = !bus.cfg_abort;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath, counters and registered outputs derived from the next state
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_core_x    <= '0;
      r_core_y    <= '0;
      r_core_z    <= '0;
      r_smp_x     <= '0;
      r_smp_y     <= '0;
      r_smp_z     <= '0;
      r_steps     <= '0;
      r_iter_cnt  <= '0;
      r_decim     <= '0;
      r_dcnt      <= '0;
      r_emit      <= 1'b0;
      r_core_req  <= 1'b0;
      r_smp_valid <= 1'b0;
      r_smp_last  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_core_req  <= (w_next == S_REQ);
      r_smp_valid <= (w_next == S_EMIT);
      r_smp_last  <= (w_next == S_EMIT) && w_last;
      r_busy      <= (w_next != S_IDLE);

      if (w_start_acc) begin
        r_core_x   <= bus.cfg_x0;
        r_core_y   <= bus.cfg_y0;
        r_core_z   <= bus.cfg_z0;
        r_steps    <= bus.cfg_steps;
        r_decim    <= (bus.cfg_decim == '0) ? DECIM_W'(1) : bus.cfg_decim;
        r_iter_cnt <= '0;
        r_dcnt     <= '0;
        r_emit     <= 1'b0;
        r_done     <= 1'b0;
      end

      if (w_ack_acc) begin
        r_core_x   <= bus.core_xn;
        r_core_y   <= bus.core_yn;
        r_core_z   <= bus.core_zn;
        r_smp_x    <= bus.core_xn;
        r_smp_y    <= bus.core_yn;
        r_smp_z    <= bus.core_zn;
        r_iter_cnt <= w_iter_inc;
        r_dcnt     <= w_dcnt_hit ? '0 : w_dcnt_inc;
        r_emit     <= w_dcnt_hit || (w_iter_inc == r_steps);
      end

      if (w_done_set) begin
        r_done <= 1'b1;
      end
    end
  end

  assign bus.core_req  = r_core_req;
  assign bus.core_x    = r_core_x;
  assign bus.core_y    = r_core_y;
  assign bus.core_z    = r_core_z;
  assign bus.smp_valid = r_smp_valid;
  assign bus.smp_x     = r_smp_x;
  assign bus.smp_y     = r_smp_y;
  assign bus.smp_z     = r_smp_z;
  assign bus.smp_last  = r_smp_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.iter_cnt  = r_iter_cnt;

endmodule

// File: tb/tb_lorenz_iter_ctrl.sv
// Bench for lorenz_iter_ctrl: a latency-programmable core model returning
// (x+1, y+1, z+1), a sample sink with selectable backpressure, and a run-level
// reference that lists which iterations should appear as samples.
module tb_lorenz_iter_ctrl;

  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  typedef struct packed {
    logic [DW-1:0] x;
    logic [DW-1:0] y;
    logic [DW-1:0] z;
    logic          last;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  lorenz_iter_ctrl_if #(.DATA_W(DW), .CNT_W(CW)) bus ();

  lorenz_iter_ctrl #(.DATA_W(DW), .CNT_W(CW)) dut (
    .ACLK   (clk),
    .ARESET (rst),
    .bus    (bus.master)
  );

  int          n_checks = 0;
  int          n_pass   = 0;

  // Core model controls and statistics
  int unsigned lat      = 4;
  bit          core_en  = 1'b1;
  int          inj_req  = 0;
  int          inj_done = 0;
  int          n_acks   = 0;
  int          n_req    = 0;
  bit          pending  = 1'b0;
  int unsigned wait_c   = 0;
  logic        prev_req = 1'b0;

  // 0: ready low, 1: ready high, 2: random
  int          rdy_mode = 1;

  smp_t        got[$];
  smp_t        exp_q[$];

  // Integration core model: ack `lat` cycles after a request, next = x+1
  always @(negedge clk) begin
    if (rst) begin
      bus.core_ack = 1'b0;
      bus.core_xn  = '0;
      bus.core_yn  = '0;
      bus.core_zn  = '0;
      pending      = 1'b0;
      prev_req     = 1'b0;
    end else begin
      if (bus.core_req && !prev_req) n_req++;
      prev_req = bus.core_req;
      if (bus.core_ack) begin
        bus.core_ack = 1'b0;
      end else if (inj_req != inj_done) begin
        inj_done     = inj_req;
        bus.core_xn  = 32'hDEAD_0001;
        bus.core_yn  = 32'hDEAD_0002;
        bus.core_zn  = 32'hDEAD_0003;
        bus.core_ack = 1'b1;
      end else if (!core_en) begin
        pending = 1'b0;
      end else if (pending) begin
        if (wait_c == 0) begin
          bus.core_xn  = bus.core_x + 32'd1;
          bus.core_yn  = bus.core_y + 32'd1;
          bus.core_zn  = bus.core_z + 32'd1;
          bus.core_ack = 1'b1;
          pending      = 1'b0;
          n_acks++;
        end else begin
          wait_c--;
        end
      end else if (bus.core_req) begin
        pending = 1'b1;
        wait_c  = lat;
      end
    end
  end

  // Sample sink ready generator
  always @(negedge clk) begin
    case (rdy_mode)
      0:       bus.smp_ready = 1'b0;
      1:       bus.smp_ready = 1'b1;
      default: bus.smp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  // Record every accepted sample
  always @(posedge clk) begin
    if (!rst && bus.smp_valid && bus.smp_ready)
      got.push_back({bus.smp_x, bus.smp_y, bus.smp_z, bus.smp_last});
  end

  // Hard stop in case something hangs
  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_run(input int unsigned steps, input int unsigned decim,
                           input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] z0);
    bus.cfg_steps = 32'(steps);
    bus.cfg_decim = 16'(decim);
    bus.cfg_x0    = x0;
    bus.cfg_y0    = y0;
    bus.cfg_z0    = z0;
    bus.cfg_start = 1'b1;
    @(negedge clk);
    bus.cfg_start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int c = 0;
    while (bus.done !== 1'b1 && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk({tag, "_done"}, 32'(bus.done), 32'd1);
  endtask

  // Reference: iteration i yields state0+i; sampled when i is a multiple of
  // the effective decimation or i is the final iteration
  task automatic build_exp(input int unsigned steps, input int unsigned decim,
                           input logic [31:0] x0, input logic [31:0] y0, input logic [31:0] z0);
    int unsigned d;
    smp_t        s;
    d = (decim == 0) ? 1 : decim;
    exp_q.delete();
    for (int unsigned i = 1; i <= steps; i++) begin
      if ((i % d) == 0 || i == steps) begin
        s.x    = x0 + 32'(i);
        s.y    = y0 + 32'(i);
        s.z    = z0 + 32'(i);
        s.last = (i == steps);
        exp_q.push_back(s);
      end
    end
  endtask

  task automatic cmp_samples(input string tag, input int base);
    smp_t g;
    chk({tag, "_nsmp"}, 32'(got.size() - base), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < got.size()) begin
        g = got[base + i];
        chk({tag, "_sx"}, g.x, exp_q[i].x);
        chk({tag, "_sy"}, g.y, exp_q[i].y);
        chk({tag, "_sz"}, g.z, exp_q[i].z);
        chk({tag, "_slast"}, 32'(g.last), 32'(exp_q[i].last));
      end
    end
  endtask

  initial begin
    int          base, b_req, b_ack, c;
    logic [31:0] ax, ay, az;
    int unsigned rs, rd;

    bus.cfg_start = 1'b0;
    bus.cfg_abort = 1'b0;
    bus.cfg_steps = '0;
    bus.cfg_decim = '0;
    bus.cfg_x0    = '0;
    bus.cfg_y0    = '0;
    bus.cfg_z0    = '0;

    // Reset values
    tick(3);
    chk("rst_req",   32'(bus.core_req),  32'd0);
    chk("rst_valid", 32'(bus.smp_valid), 32'd0);
    chk("rst_last",  32'(bus.smp_last),  32'd0);
    chk("rst_busy",  32'(bus.busy),      32'd0);
    chk("rst_done",  32'(bus.done),      32'd0);
    chk("rst_iter",  bus.iter_cnt,       32'd0);
    chk("rst_cx",    bus.core_x,         32'd0);
    chk("rst_sx",    bus.smp_x,          32'd0);
    rst = 1'b0;
    tick(2);

    // Basic run: steps=3, decim=1, state 1/2/3, latency 4
    rdy_mode = 1; lat = 4; core_en = 1'b1;
    b_req = n_req; base = got.size();
    start_run(3, 1, 32'd1, 32'd2, 32'd3);
    chk("s1_busy", 32'(bus.busy), 32'd1);
    chk("s1_req",  32'(bus.core_req), 32'd1);
    chk("s1_cx",   bus.core_x, 32'd1);
    chk("s1_cy",   bus.core_y, 32'd2);
    chk("s1_cz",   bus.core_z, 32'd3);
    chk("s1_done0", 32'(bus.done), 32'd0);
    c = 0;
    while (!(bus.smp_valid === 1'b1 && bus.smp_last === 1'b1) && c < 200) begin
      tick(1); c++;
    end
    tick(1);
    chk("s1_busy_in_done", 32'(bus.busy), 32'd1);
    chk("s1_done_lag",     32'(bus.done), 32'd0);
    tick(1);
    chk("s1_done", 32'(bus.done), 32'd1);
    chk("s1_busy_end", 32'(bus.busy), 32'd0);
    chk("s1_iter", bus.iter_cnt, 32'd3);
    chk("s1_reqs", 32'(n_req - b_req), 32'd3);
    build_exp(3, 1, 32'd1, 32'd2, 32'd3);
    cmp_samples("s1", base);

    // Decimated run: steps=10, decim=4; check ack-to-next-request timing
    ax = $urandom; ay = $urandom; az = $urandom;
    b_ack = n_acks; base = got.size(); lat = 3;
    start_run(10, 4, ax, ay, az);
    c = 0;
    do begin
      @(posedge clk); c++;
    end while (bus.core_ack !== 1'b1 && c < 100);
    @(negedge clk);
    chk("s2_step_req", 32'(bus.core_req), 32'd0);
    @(negedge clk);
    chk("s2_rereq", 32'(bus.core_req), 32'd1);
    chk("s2_fb_x", bus.core_x, ax + 32'd1);
    chk("s2_fb_z", bus.core_z, az + 32'd1);
    wait_done("s2", 1000);
    chk("s2_iter", bus.iter_cnt, 32'd10);
    chk("s2_acks", 32'(n_acks - b_ack), 32'd10);
    build_exp(10, 4, ax, ay, az);
    cmp_samples("s2", base);

    // Backpressure at the first sample
    rdy_mode = 0; tick(1);
    ax = $urandom; ay = $urandom; az = $urandom;
    base = got.size();
    start_run(2, 1, ax, ay, az);
    c = 0;
    while (bus.smp_valid !== 1'b1 && c < 100) begin
      tick(1); c++;
    end
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", 32'(bus.smp_valid), 32'd1);
      chk("bp_sx",    bus.smp_x, ax + 32'd1);
      chk("bp_sy",    bus.smp_y, ay + 32'd1);
      chk("bp_req",   32'(bus.core_req), 32'd0);
      chk("bp_iter",  bus.iter_cnt, 32'd1);
      tick(1);
    end
    rdy_mode = 1;
    wait_done("bp", 500);
    build_exp(2, 1, ax, ay, az);
    cmp_samples("bp", base);

    // Abort in REQ after 5 of 10 iterations, then a stray late ack
    lat = 2;
    ax = $urandom; ay = $urandom; az = $urandom;
    start_run(10, 1, ax, ay, az);
    c = 0;
    while (!(bus.iter_cnt === 32'd5 && bus.core_req === 1'b1) && c < 500) begin
      tick(1); c++;
    end
    bus.cfg_abort = 1'b1;
    tick(1);
    bus.cfg_abort = 1'b0;
    core_en = 1'b0;
    chk("ab_busy",  32'(bus.busy), 32'd0);
    chk("ab_req",   32'(bus.core_req), 32'd0);
    chk("ab_done",  32'(bus.done), 32'd0);
    chk("ab_iter",  bus.iter_cnt, 32'd5);
    chk("ab_cx",    bus.core_x, ax + 32'd5);
    chk("ab_valid", 32'(bus.smp_valid), 32'd0);
    tick(2);
    inj_req++;
    tick(3);
    chk("ab_late_iter", bus.iter_cnt, 32'd5);
    chk("ab_late_busy", 32'(bus.busy), 32'd0);
    chk("ab_late_cx",   bus.core_x, ax + 32'd5);
    chk("ab_late_done", 32'(bus.done), 32'd0);
    core_en = 1'b1; tick(1);
    ax = $urandom; ay = $urandom; az = $urandom;
    base = got.size();
    start_run(1, 3, ax, ay, az);
    wait_done("ab_rerun", 200);
    chk("ab_rerun_iter", bus.iter_cnt, 32'd1);
    build_exp(1, 3, ax, ay, az);
    cmp_samples("ab_rerun", base);

    // Zero-step run and start+abort collision in IDLE
    b_req = n_req; base = got.size();
    start_run(0, 1, 32'd7, 32'd8, 32'd9);
    chk("z_busy",  32'(bus.busy), 32'd1);
    chk("z_done0", 32'(bus.done), 32'd0);
    chk("z_req",   32'(bus.core_req), 32'd0);
    tick(1);
    chk("z_done",  32'(bus.done), 32'd1);
    chk("z_busy_end", 32'(bus.busy), 32'd0);
    tick(2);
    chk("z_reqs",  32'(n_req - b_req), 32'd0);
    chk("z_nsmp",  32'(got.size() - base), 32'd0);
    bus.cfg_abort = 1'b1;
    start_run(5, 1, 32'd1, 32'd1, 32'd1);
    bus.cfg_abort = 1'b0;
    chk("sa_busy", 32'(bus.busy), 32'd0);
    chk("sa_req",  32'(bus.core_req), 32'd0);
    chk("sa_done", 32'(bus.done), 32'd1);
    tick(3);
    chk("sa_busy2", 32'(bus.busy), 32'd0);

    // Reset while waiting in EMIT
    rdy_mode = 0; tick(1);
    start_run(4, 1, 32'd100, 32'd200, 32'd300);
    c = 0;
    while (bus.smp_valid !== 1'b1 && c < 100) begin
      tick(1); c++;
    end
    chk("re_in_emit", 32'(bus.smp_valid), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("re_valid", 32'(bus.smp_valid), 32'd0);
    chk("re_last",  32'(bus.smp_last), 32'd0);
    chk("re_busy",  32'(bus.busy), 32'd0);
    chk("re_done",  32'(bus.done), 32'd0);
    chk("re_iter",  bus.iter_cnt, 32'd0);
    chk("re_sx",    bus.smp_x, 32'd0);
    chk("re_cx",    bus.core_x, 32'd0);
    rdy_mode = 1; tick(2);

    // Start pulse while busy is ignored
    b_ack = n_acks; base = got.size();
    ax = $urandom; ay = $urandom; az = $urandom;
    start_run(4, 1, ax, ay, az);
    tick(3);
    start_run(7, 2, 32'd0, 32'd0, 32'd0);
    wait_done("sb", 500);
    chk("sb_iter", bus.iter_cnt, 32'd4);
    chk("sb_acks", 32'(n_acks - b_ack), 32'd4);
    build_exp(4, 1, ax, ay, az);
    cmp_samples("sb", base);

    // Randomized runs with random latency, decimation and backpressure
    rdy_mode = 2;
    for (int r = 0; r < 8; r++) begin
      rs  = $urandom_range(1, 12);
      rd  = $urandom_range(0, 5);
      lat = $urandom_range(0, 3);
      ax = $urandom; ay = $urandom; az = $urandom;
      tick(1);
      b_ack = n_acks; base = got.size();
      start_run(rs, rd, ax, ay, az);
      wait_done("rnd", 2000);
      chk("rnd_iter", bus.iter_cnt, 32'(rs));
      chk("rnd_acks", 32'(n_acks - b_ack), 32'(rs));
      build_exp(rs, rd, ax, ay, az);
      cmp_samples("rnd", base);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/lorenz_iter_ctrl.md
# lorenz_iter_ctrl

Sequencing controller for the Lorenz attractor integration core inside the myip_lorenz AXI4-Lite peripheral. It takes a run configuration from the slave register bank: initial state, step count, decimation factor and start/abort pulses. It then drives the integration core one Euler step at a time, feeding each result back as the next operand. Every Nth state vector, and always the final one, is emitted on a ready/valid sample port. It reports busy, done and the iteration count back to the register bank.

## Interface
- DATA_W, 32, width of each state variable x/y/z (fixed-point, opaque to this block)
- CNT_W, 32, width of step count and iteration counter
- ACLK  in  1  clock
- ARESET  in  1  synchronous reset, active-high
- cfg_start  in  1  one-cycle start pulse
- cfg_abort  in  1  one-cycle abort pulse
- cfg_steps  in  CNT_W  iterations to run; sampled on accepted start
- cfg_decim  in  16  emit every cfg_decim-th iteration; 0 treated as 1; sampled on accepted start
- cfg_x0, cfg_y0, cfg_z0  in  DATA_W  initial state; sampled on accepted start
- core_req  out  1  operand valid / step request to integration core
- core_x, core_y, core_z  out  DATA_W  operands; stable while core_req=1
- core_ack  in  1  one-cycle step-complete pulse; honoured only in REQ
- core_xn, core_yn, core_zn  in  DATA_W  next state, valid with core_ack
- smp_valid  out  1  sample valid
- smp_ready  in  1  sample accept
- smp_x, smp_y, smp_z  out  DATA_W  sample data
- smp_last  out  1  sample is final iteration
- busy  out  1  run in progress
- done  out  1  sticky; set on normal completion, cleared by next accepted start or reset
- iter_cnt  out  CNT_W  completed iterations of current/last run

## Operation
- States: IDLE, REQ, STEP, EMIT, DONE.
- IDLE: cfg_start accepted only here and only if cfg_abort=0.
  - cfg_steps=0 -> DONE directly.
  - Otherwise -> REQ: load operands from cfg_x0..z0, latch steps/decim, clear iter_cnt, clear decim counter, clear done.
- REQ: core_req=1, operands held.
  - On core_ack: operands and smp registers <= core_xn..zn; iter_cnt += 1; decim counter increments, wrapping to 0 at latched decim.
  - Emit flag registered = (decim counter hit) OR (iter_cnt+1 == steps).
  - -> STEP.
- STEP: core_req=0 for exactly this one cycle.
  - -> EMIT if emit flag set.
  - Else -> REQ if iter_cnt < steps.
- EMIT: smp_valid=1; smp_last=1 iff iter_cnt==steps.
  - On smp_ready: -> DONE if iter_cnt==steps, else -> REQ.
  - The core is stalled while waiting; no request is issued.
- DONE: one cycle; done<=1, busy<=0 on exit; -> IDLE.
- cfg_abort in any non-IDLE state:
  - -> IDLE next edge; core_req, smp_valid, busy drop.
  - done stays 0; iter_cnt holds its value.
  - Abort overrides start, ack and ready in the same cycle.
- core_ack outside REQ is ignored, including a late ack after abort.
- cfg_start while busy is ignored.
- iter_cnt never wraps: steps ≤ 2^CNT_W-1 and counting stops at steps.

## Timing
- Reset: state IDLE. core_req, smp_valid, smp_last, busy, done = 0. iter_cnt, operands, smp data = 0.
- cfg_start sampled at edge k: busy=1 and core_req=1 from k+1, core_x=cfg_x0.
- core_ack at edge m: core_req=0 at m+1 (STEP).
  - At m+2 either core_req=1 with core_x=core_xn, or smp_valid=1.
  - Per-iteration cost without emit = core latency + 2 cycles.
- smp_valid/data/last stable until smp_ready handshake. Next core_req rises 1 cycle after the handshake.
- Final handshake at edge h: DONE at h+1; done=1, busy=0 at h+2.
- cfg_steps=0 start at k: DONE at k+1; done=1 at k+2; core_req never asserted.
- busy is high from k+1 through the DONE cycle inclusive.

## Test plan
- steps=3, decim=1, x0/y0/z0=1/2/3, core model latency 4 returning (x+1,y+1,z+1): 3 core_req pulses, samples (2,3,4),(3,4,5),(4,5,6), smp_last on the third only, then done=1, iter_cnt=3, busy=0.
- steps=10, decim=4, smp_ready tied high: samples after iterations 4, 8 and 10 only; smp_last on iteration 10; exactly 10 acks consumed.
- Backpressure: steps=2, decim=1, smp_ready low for 20 cycles at the first sample: smp_valid and data stable throughout, core_req=0, iter_cnt=1. After release, run completes with 2 samples.
- Abort while in REQ at iteration 5 of 10: next cycle busy=0, core_req=0, done=0, iter_cnt=5. A core_ack injected 3 cycles later changes nothing. A subsequent start with steps=1 completes normally.
- steps=0 start: done=1 two cycles later; no core_req, no smp_valid. cfg_start and cfg_abort in the same cycle from IDLE: no state change.
- ARESET asserted mid-EMIT: next cycle all outputs at reset values, done=0. cfg_start pulsed while busy (steps=4 run) is ignored: exactly 4 iterations.
